// File: rtl/intfmux_pkg.sv
// rtl/intfmux_pkg.sv - shared constants and sync-state codes for the TDM link mux/demux
package intfmux_pkg;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_PRESYNC = 2'd1,
      ST_SYNC    = 2'd2
   } sync_state_e;

   localparam int FRMLEN_DEF = 8;
   localparam int PH_W       = 3;

endpackage

// File: rtl/intfsyn_fsm.sv
// rtl/intfsyn_fsm.sv - frame-sync acquisition with flywheel for the TDM demux
module intfsyn_fsm
   import intfmux_pkg::*;
#(
   parameter int SYNCNT = 2,
   parameter int LOSCNT = 3
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic isyn_i,
   input  logic expect_i,
   output logic frm_start_o,
   output logic oinsync_o,
   output logic oerr_o
);

   localparam int GW = (SYNCNT > 1) ? $clog2(SYNCNT + 1) : 1;
   localparam int EW = (LOSCNT > 1) ? $clog2(LOSCNT + 1) : 1;
   localparam logic [GW-1:0] GOOD_LAST = GW'(SYNCNT - 1);
   localparam logic [EW-1:0] ERR_LAST  = EW'(LOSCNT - 1);

   sync_state_e      state_q;
   logic [GW-1:0]    good_q;
   logic [EW-1:0]    errcnt_q;
   logic             oinsync_q;
   logic             oerr_q;

   // In SYNC the slot counter alone decides alignment; early isyn never re-seeds it.
   assign frm_start_o = (state_q == ST_SYNC) ? expect_i : isyn_i;
   assign oinsync_o   = oinsync_q;
   assign oerr_o      = oerr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_HUNT;
         good_q    <= '0;
         errcnt_q  <= '0;
         oinsync_q <= 1'b0;
         oerr_q    <= 1'b0;
      end else begin
         oerr_q <= 1'b0;
         case (state_q)
            ST_HUNT: begin
               if (isyn_i) begin
                  good_q <= GW'(1);
                  if (SYNCNT <= 1) begin
                     state_q   <= ST_SYNC;
                     errcnt_q  <= '0;
                     oinsync_q <= 1'b1;
                  end else begin
                     state_q <= ST_PRESYNC;
                  end
               end
            end
            ST_PRESYNC: begin
               if (isyn_i && expect_i) begin
                  if (good_q >= GOOD_LAST) begin
                     state_q   <= ST_SYNC;
                     errcnt_q  <= '0;
                     oinsync_q <= 1'b1;
                  end else begin
                     good_q <= good_q + GW'(1);
                  end
               end else if (isyn_i) begin
                  oerr_q <= 1'b1;
                  good_q <= GW'(1);
               end else if (expect_i) begin
                  oerr_q  <= 1'b1;
                  good_q  <= '0;
                  state_q <= ST_HUNT;
               end
            end
            ST_SYNC: begin
               if (isyn_i && expect_i) begin
                  errcnt_q <= '0;
               end else if (isyn_i || expect_i) begin
                  oerr_q <= 1'b1;
                  if (errcnt_q >= ERR_LAST) begin
                     state_q   <= ST_HUNT;
                     errcnt_q  <= '0;
                     good_q    <= '0;
                     oinsync_q <= 1'b0;
                  end else begin
                     errcnt_q <= errcnt_q + EW'(1);
                  end
               end
            end
            default: begin
               state_q   <= ST_HUNT;
               oinsync_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/intfdmux6.sv
// rtl/intfdmux6.sv - receive-side TDM demux rebuilding MUX-word groups from the serial link
module intfdmux6
   import intfmux_pkg::*;
#(
   parameter int LINEBIT = 12,
   parameter int MUX     = 6,
   parameter int FRMLEN  = FRMLEN_DEF,
   parameter int SYNCNT  = 2,
   parameter int LOSCNT  = 3
) (
   input  logic                   iclk38,
   input  logic                   rst_,
   input  logic [LINEBIT-1:0]     idat,
   input  logic                   isyn,
   output logic [LINEBIT*MUX-1:0] odat,
   output logic                   ovld,
   output logic                   oinsync,
   output logic                   oerr
);

   localparam int DATABIT = LINEBIT * MUX;

   logic [PH_W-1:0]               cntph_q, cntph_d;
   logic [MUX-1:0][LINEBIT-1:0]   cap_q, cap_d;
   logic                          arm_q, arm_d;
   logic                          full_q;
   logic                          last_wr;
   logic [DATABIT-1:0]            odat_q;
   logic                          ovld_q;
   logic                          frm_start;
   logic                          expect_slot;

   assign expect_slot = (cntph_q == '0);

   intfsyn_fsm #(
      .SYNCNT (SYNCNT),
      .LOSCNT (LOSCNT)
   ) u_fsm (
      .clk_i       (iclk38),
      .rst_ni      (rst_),
      .isyn_i      (isyn),
      .expect_i    (expect_slot),
      .frm_start_o (frm_start),
      .oinsync_o   (oinsync),
      .oerr_o      (oerr)
   );

   always_comb begin
      cntph_d = cntph_q;
      if (frm_start) begin
         cntph_d = (FRMLEN > 1) ? PH_W'(1) : '0;
      end else if (cntph_q == PH_W'(FRMLEN - 1)) begin
         cntph_d = '0;
      end else begin
         cntph_d = cntph_q + PH_W'(1);
      end
   end

   // arm_q marks a group in progress; a fresh start always wins over the last-slot write.
   always_comb begin
      cap_d   = cap_q;
      arm_d   = arm_q;
      last_wr = 1'b0;
      if (frm_start) begin
         cap_d[MUX-1] = idat;
         arm_d        = (MUX > 1);
         last_wr      = (MUX == 1);
      end else if (arm_q) begin
         for (int k = 1; k < MUX; k++) begin
            if (cntph_q == PH_W'(k)) begin
               cap_d[MUX-1-k] = idat;
            end
         end
         if (cntph_q == PH_W'(MUX - 1)) begin
            last_wr = 1'b1;
            arm_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge iclk38 or negedge rst_) begin
      if (!rst_) begin
         cntph_q <= '0;
         cap_q   <= '0;
         arm_q   <= 1'b0;
         full_q  <= 1'b0;
         odat_q  <= '0;
         ovld_q  <= 1'b0;
      end else begin
         cntph_q <= cntph_d;
         cap_q   <= cap_d;
         arm_q   <= arm_d;
         full_q  <= last_wr;
         ovld_q  <= full_q;
         if (full_q) begin
            odat_q <= cap_q;
         end
      end
   end

   assign odat = odat_q;
   assign ovld = ovld_q;

endmodule

// File: tb/tb_intfdmux6.sv
// tb/tb_intfdmux6.sv - randomized self-checking bench for intfdmux6 against a history-based model
module tb_intfdmux6;

   localparam int LB = 12;
   localparam int MX = 6;
   localparam int FL = 8;
   localparam int SC = 2;
   localparam int LC = 3;
   localparam int DB = LB * MX;
   localparam int HN = 8192;

   logic          iclk38 = 1'b0;
   logic          rst_   = 1'b0;
   logic [LB-1:0] idat   = '0;
   logic          isyn   = 1'b0;
   logic [DB-1:0] odat;
   logic          ovld;
   logic          oinsync;
   logic          oerr;

   intfdmux6 #(
      .LINEBIT (LB),
      .MUX     (MX),
      .FRMLEN  (FL),
      .SYNCNT  (SC),
      .LOSCNT  (LC)
   ) dut (
      .iclk38  (iclk38),
      .rst_    (rst_),
      .idat    (idat),
      .isyn    (isyn),
      .odat    (odat),
      .ovld    (ovld),
      .oinsync (oinsync),
      .oerr    (oerr)
   );

   always #5 iclk38 = ~iclk38;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Model: 0 = hunting, 1 = confirming, 2 = locked; outputs derived from the start history.
   int            m_state, m_good, m_errc, m_n, m_last;
   bit            st_h [HN];
   logic [LB-1:0] dat_h [HN];
   logic [DB-1:0] e_odat;
   bit            e_ovld, e_err, e_sync;

   task automatic model_reset();
      m_state = 0; m_good = 0; m_errc = 0; m_n = 0; m_last = 0;
      e_odat = '0; e_ovld = 0; e_err = 0; e_sync = 0;
   endtask

   task automatic model_edge(input bit s, input logic [LB-1:0] d);
      bit exp_slot, start, err, ok;
      int s0;
      exp_slot = (m_state != 0) && (m_n > m_last) && (((m_n - m_last) % FL) == 0);
      start    = (m_state == 2) ? exp_slot : s;
      err      = 0;
      if (m_state == 0) begin
         if (s) begin m_state = 1; m_good = 1; end
      end else if (m_state == 1) begin
         if (s && exp_slot) begin
            m_good++;
            if (m_good >= SC) begin m_state = 2; m_errc = 0; end
         end else if (s) begin
            err = 1; m_good = 1;
         end else if (exp_slot) begin
            err = 1; m_state = 0;
         end
      end else begin
         if (s && exp_slot) m_errc = 0;
         else if (s || exp_slot) begin
            err = 1; m_errc++;
            if (m_errc >= LC) begin m_state = 0; m_errc = 0; end
         end
      end
      st_h[m_n]  = start;
      dat_h[m_n] = d;
      if (start) m_last = m_n;
      e_ovld = 0;
      s0 = m_n - MX;
      if (s0 >= 0 && st_h[s0]) begin
         ok = 1;
         for (int j = s0 + 1; j < m_n; j++) if (st_h[j]) ok = 0;
         if (ok) begin
            e_ovld = 1;
            for (int k = 0; k < MX; k++) e_odat[DB-1-k*LB -: LB] = dat_h[s0+k];
         end
      end
      e_err  = err;
      e_sync = (m_state == 2);
      m_n++;
   endtask

   task automatic cyc(input bit s, input logic [LB-1:0] d);
      isyn = s;
      idat = d;
      @(posedge iclk38);
      model_edge(s, d);
      @(negedge iclk38);
      chk("ovld", {71'd0, ovld}, {71'd0, e_ovld});
      chk("oinsync", {71'd0, oinsync}, {71'd0, e_sync});
      chk("oerr", {71'd0, oerr}, {71'd0, e_err});
      chk("odat", odat, e_odat);
   endtask

   task automatic frame(input bit drop, input int inj_p, input bit loopback);
      bit            s;
      logic [LB-1:0] d;
      for (int p = 0; p < FL; p++) begin
         s = (p == 0 && !drop) || (inj_p > 0 && p == inj_p);
         if (p < MX && loopback) d = LB'(12'h111 * (p + 1));
         else                    d = LB'($urandom);
         cyc(s, d);
      end
   endtask

   task automatic do_reset(input string tag);
      rst_ = 1'b0;
      isyn = 1'b0;
      model_reset();
      @(negedge iclk38);
      @(negedge iclk38);
      chk({tag, "_odat"}, odat, '0);
      chk({tag, "_ovld"}, {71'd0, ovld}, '0);
      chk({tag, "_oinsync"}, {71'd0, oinsync}, '0);
      chk({tag, "_oerr"}, {71'd0, oerr}, '0);
      rst_ = 1'b1;
   endtask

   initial begin
      int ovld_seen;
      int mode;
      do_reset("rst");

      // Two starts 4 cycles apart while hunting: only the second group completes.
      ovld_seen = 0;
      for (int c = 0; c < 13; c++) begin
         cyc(c == 0 || c == 4, LB'($urandom));
         if (c < 10 && ovld) ovld_seen++;
      end
      chk("hunt_abort_ovld", 72'(ovld_seen), 72'd0);

      do_reset("rst2");
      repeat (4) frame(0, 0, 1);
      chk("loop_lock", {71'd0, oinsync}, 72'd1);
      chk("loop_odat", odat, 72'h111222333444555666);

      frame(1, 0, 1);
      repeat (2) frame(0, 0, 1);
      chk("drop1_sync", {71'd0, oinsync}, 72'd1);

      repeat (3) frame(1, 0, 1);
      chk("drop3_hunt", {71'd0, oinsync}, 72'd0);
      repeat (2) frame(0, 0, 1);
      chk("relock", {71'd0, oinsync}, 72'd1);

      frame(0, 3, 1);
      frame(0, 0, 1);
      chk("inject_sync", {71'd0, oinsync}, 72'd1);
      chk("inject_odat", odat, 72'h111222333444555666);

      for (int p = 0; p < 7; p++) cyc(p == 0, LB'(12'h111 * (p + 1)));
      #2 rst_ = 1'b0;
      #1;
      chk("mid_rst_odat", odat, '0);
      chk("mid_rst_ovld", {71'd0, ovld}, '0);
      chk("mid_rst_oinsync", {71'd0, oinsync}, '0);
      chk("mid_rst_oerr", {71'd0, oerr}, '0);
      @(negedge iclk38);
      model_reset();
      rst_ = 1'b1;
      for (int c = 0; c < 5; c++) cyc(1'b0, LB'($urandom));
      repeat (3) frame(0, 0, 0);

      for (int f = 0; f < 100; f++) begin
         mode = int'($urandom_range(0, 9));
         if (mode == 0)      frame(1, 0, 0);
         else if (mode == 1) frame(0, int'($urandom_range(1, FL - 1)), 0);
         else if (mode == 2) frame(1, int'($urandom_range(1, FL - 1)), 0);
         else                frame(0, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
